// File: rtl/spi_reg_bank_if.sv
// spi_reg_bank_if: SPI pin bundle between an SPI controller and the register bank.
//   sclk, copi, ncs : controller -> peripheral (asynchronous to clk)
//   cipo, cipo_oe   : peripheral -> pad
interface spi_reg_bank_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;
    logic cipo_oe;
    modport master (output sclk, copi, ncs, input cipo, cipo_oe);
    modport slave (input sclk, copi, ncs, output cipo, cipo_oe);
endinterface

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 peripheral exposing NUM_REGS x DATA_W registers with write and read-back frames.
//   clk, rst_n : system clock, asynchronous active-low reset
//   spi        : SPI pins (sclk/copi/ncs in, cipo/cipo_oe out)
//   regs_o     : register contents, register i at [i*DATA_W +: DATA_W]
//   wr_stb     : one-cycle pulse per committed write, wr_addr holds its address
//   frame_err  : one-cycle pulse per rejected frame
module spi_reg_bank #(
    parameter int NUM_REGS = 4,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    spi_reg_bank_if.slave              spi,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic                       wr_stb,
    output logic [6:0]                 wr_addr,
    output logic                       frame_err
);
    localparam int FRAME_W = 8 + DATA_W;
    localparam int CW = $clog2(FRAME_W + 2);
    localparam int AW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    logic [2:0] sclk_q, ncs_q;
    logic [1:0] copi_q, vld;
    logic armed, rd, cipo_r;
    logic [CW-1:0] cnt;
    logic [FRAME_W-1:0] rx, rx_n;
    logic [DATA_W-1:0] tx;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [6:0] rx_addr, rd_addr;
    logic sclk_rise, sclk_fall, ncs_rise, ncs_fall, rx_ok, rd_ok;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign ncs_rise = ncs_q[1] & ~ncs_q[2];
    assign ncs_fall = ~ncs_q[1] & ncs_q[2];
    assign rx_n = {rx[FRAME_W-2:0], copi_q[1]};
    assign rx_addr = rx[FRAME_W-2 -: 7];
    // Address of a read as it completes: the 8th bit is still being shifted in.
    assign rd_addr = rx_n[6:0];
    assign rx_ok = cnt == CW'(FRAME_W) && {1'b0, rx_addr} < 8'(NUM_REGS);
    assign rd_ok = {1'b0, rd_addr} < 8'(NUM_REGS);
    assign spi.cipo = cipo_r;
    assign spi.cipo_oe = ~ncs_q[1];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign regs_o[i*DATA_W +: DATA_W] = regs[i];
    end

    // armed stays low after reset until ncs is seen high through the synchroniser,
    // so a chip select still low at reset release cannot open a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            copi_q <= '0;
            ncs_q <= '1;
            vld <= '0;
            armed <= 1'b0;
            cnt <= '0;
            rx <= '0;
            tx <= '0;
            rd <= 1'b0;
            cipo_r <= 1'b0;
            wr_stb <= 1'b0;
            wr_addr <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], spi.sclk};
            copi_q <= {copi_q[0], spi.copi};
            ncs_q <= {ncs_q[1:0], spi.ncs};
            vld <= {vld[0], 1'b1};
            armed <= armed | (vld[1] & ncs_q[1]);
            wr_stb <= 1'b0;
            frame_err <= 1'b0;
            if (armed && ncs_fall) begin
                cnt <= '0;
                rx <= '0;
                rd <= 1'b0;
            end else if (armed && ncs_rise) begin
                // A coincident sclk edge is dropped: the commit sees the prior state.
                if (rx_ok && rx[FRAME_W-1]) begin
                    regs[rx_addr[AW-1:0]] <= rx[DATA_W-1:0];
                    wr_stb <= 1'b1;
                    wr_addr <= rx_addr;
                end else if (!rx_ok) begin
                    frame_err <= 1'b1;
                end
                rd <= 1'b0;
            end else if (armed && !ncs_q[1]) begin
                if (sclk_rise) begin
                    rx <= rx_n;
                    if (cnt != CW'(FRAME_W + 1)) cnt <= cnt + 1'b1;
                    if (cnt == CW'(7) && !rx_n[7]) begin
                        rd <= 1'b1;
                        tx <= rd_ok ? regs[rd_addr[AW-1:0]] : '0;
                    end
                end
                if (sclk_fall && rd) begin
                    cipo_r <= tx[DATA_W-1];
                    tx <= tx << 1;
                end
            end
            if (!armed || ncs_q[1]) cipo_r <= 1'b0;
        end
    end
endmodule
